// File: rtl/ft_tx_arbiter.sv
// ft_tx_arbiter: frames telemetry packets and status snapshots into 16-bit FT transmit FIFO words.
// Status frames exist only with `define FT_TX_STATUS_EN; the default build sends packet frames only.
module ft_tx_arbiter #(
    parameter logic [15:0] HDR_PKT  = 16'h5AA5,
    parameter logic [15:0] HDR_STAT = 16'hA55A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pkt_valid,
    input  logic [87:0] pkt_data,
    input  logic        stat_req,
    input  logic [31:0] total_packets,
    input  logic [31:0] mismatch_packets,
    output logic [15:0] ui_din,
    output logic [1:0]  ui_din_be,
    output logic        ui_din_valid,
    input  logic        ui_din_full,
    output logic [15:0] drop_count,
    output logic        busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PKT  = 2'd1;
`ifdef FT_TX_STATUS_EN
    localparam logic [1:0] S_STAT = 2'd2;
`endif

    logic [1:0]  r_rst_sync;
    logic        w_run;
    logic [1:0]  r_state;
    logic [2:0]  r_idx;
    logic [2:0]  w_nidx;
    logic        r_buf_full;
    logic [87:0] r_buf;
    logic [15:0] w_pkt_word;
    logic        w_acc;
    logic        w_last_pkt;
    logic        w_drop;
    logic        w_start_pkt;

    assign w_run      = r_rst_sync[1];
    assign w_acc      = ui_din_valid & ~ui_din_full;
    assign w_nidx     = r_idx + 3'd1;
    assign w_last_pkt = (r_state == S_PKT) && (r_idx == 3'd6) && w_acc;
    assign w_drop     = pkt_valid & r_buf_full & ~w_last_pkt;

    // Reset release is synchronised so the FSM never leaves IDLE on a partial first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    always_comb begin
        case (w_nidx)
            3'd1:    w_pkt_word = r_buf[15:0];
            3'd2:    w_pkt_word = r_buf[31:16];
            3'd3:    w_pkt_word = r_buf[47:32];
            3'd4:    w_pkt_word = r_buf[63:48];
            3'd5:    w_pkt_word = r_buf[79:64];
            default: w_pkt_word = {8'h00, r_buf[87:80]};
        endcase
    end

`ifdef FT_TX_STATUS_EN
    logic        r_stat_pend;
    logic        r_last_pkt;
    logic        w_start_stat;
    logic [31:0] r_snap_tot;
    logic [31:0] r_snap_mis;
    logic [15:0] r_snap_drop;
    logic [15:0] w_stat_word;

    // Round-robin: on contention the class not served last wins.
    assign w_start_pkt  = (r_state == S_IDLE) & w_run & r_buf_full & (~r_stat_pend | ~r_last_pkt);
    assign w_start_stat = (r_state == S_IDLE) & w_run & r_stat_pend & ~w_start_pkt;

    always_comb begin
        case (w_nidx)
            3'd1:    w_stat_word = r_snap_tot[15:0];
            3'd2:    w_stat_word = r_snap_tot[31:16];
            3'd3:    w_stat_word = r_snap_mis[15:0];
            3'd4:    w_stat_word = r_snap_mis[31:16];
            default: w_stat_word = r_snap_drop;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_pend <= 1'b0;
            r_last_pkt  <= 1'b0;
            r_snap_tot  <= '0;
            r_snap_mis  <= '0;
            r_snap_drop <= '0;
        end else begin
            r_stat_pend <= ~w_start_stat & (r_stat_pend | stat_req);
            r_last_pkt  <= w_start_pkt ? 1'b1 : (w_start_stat ? 1'b0 : r_last_pkt);
            if (w_start_stat) begin
                r_snap_tot  <= total_packets;
                r_snap_mis  <= mismatch_packets;
                r_snap_drop <= drop_count;
            end
        end
    end
`else
    logic w_unused;
    assign w_start_pkt = (r_state == S_IDLE) & w_run & r_buf_full;
    assign w_unused    = ^{stat_req, total_packets, mismatch_packets, HDR_STAT};
`endif

    // The buffer frees on the last-word accept, so a packet arriving that same cycle is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            drop_count <= '0;
        end else begin
            if (pkt_valid && (!r_buf_full || w_last_pkt)) begin
                r_buf      <= pkt_data;
                r_buf_full <= 1'b1;
            end else if (w_last_pkt) begin
                r_buf_full <= 1'b0;
            end
            if (w_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            ui_din       <= '0;
            ui_din_be    <= '0;
            ui_din_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_pkt) begin
                        r_state      <= S_PKT;
                        r_idx        <= '0;
                        ui_din       <= HDR_PKT;
                        ui_din_be    <= 2'b11;
                        ui_din_valid <= 1'b1;
                        busy         <= 1'b1;
`ifdef FT_TX_STATUS_EN
                    end else if (w_start_stat) begin
                        r_state      <= S_STAT;
                        r_idx        <= '0;
                        ui_din       <= HDR_STAT;
                        ui_din_be    <= 2'b11;
                        ui_din_valid <= 1'b1;
                        busy         <= 1'b1;
`endif
                    end
                end
                S_PKT: begin
                    if (w_acc && r_idx == 3'd6) begin
                        r_state      <= S_IDLE;
                        ui_din       <= '0;
                        ui_din_be    <= '0;
                        ui_din_valid <= 1'b0;
                        busy         <= 1'b0;
                    end else if (w_acc) begin
                        r_idx     <= w_nidx;
                        ui_din    <= w_pkt_word;
                        ui_din_be <= (w_nidx == 3'd6) ? 2'b01 : 2'b11;
                    end
                end
`ifdef FT_TX_STATUS_EN
                S_STAT: begin
                    if (w_acc && r_idx == 3'd5) begin
                        r_state      <= S_IDLE;
                        ui_din       <= '0;
                        ui_din_be    <= '0;
                        ui_din_valid <= 1'b0;
                        busy         <= 1'b0;
                    end else if (w_acc) begin
                        r_idx     <= w_nidx;
                        ui_din    <= w_stat_word;
                        ui_din_be <= 2'b11;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ft_tx_arbiter.sv
// tb_ft_tx_arbiter: directed self-checking bench for ft_tx_arbiter.
module tb_ft_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pkt_valid = 1'b0;
    logic [87:0] pkt_data = '0;
    logic        stat_req = 1'b0;
    logic [31:0] total_packets = '0;
    logic [31:0] mismatch_packets = '0;
    logic [15:0] ui_din;
    logic [1:0]  ui_din_be;
    logic        ui_din_valid;
    logic        ui_din_full = 1'b0;
    logic [15:0] drop_count;
    logic        busy;
    int checks = 0;
    int errors = 0;

    ft_tx_arbiter dut (
        .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
        .stat_req(stat_req), .total_packets(total_packets), .mismatch_packets(mismatch_packets),
        .ui_din(ui_din), .ui_din_be(ui_din_be), .ui_din_valid(ui_din_valid),
        .ui_din_full(ui_din_full), .drop_count(drop_count), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pkt_word(input logic [87:0] d, input int i);
        if (i == 0) return 16'h5AA5;
        if (i == 6) return {8'h00, d[87:80]};
        return d[16*(i-1) +: 16];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (ui_din !== 16'h0000) begin errors++; $display("FAIL reset_din: got %h want 0000", ui_din); end
        checks++; if (ui_din_be !== 2'b00) begin errors++; $display("FAIL reset_be: got %b want 00", ui_din_be); end
        checks++; if (ui_din_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ui_din_valid); end
        checks++; if (drop_count !== 16'h0000) begin errors++; $display("FAIL reset_drop: got %h want 0000", drop_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        repeat (3) tick();
        checks++; if (ui_din_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_release: valid %b busy %b want 0 0", ui_din_valid, busy); end
    endtask

    task automatic test_packet();
        logic [15:0] exp_w [7] = '{16'h5AA5, 16'h8899, 16'h6677, 16'h4455, 16'h2233, 16'h0011, 16'h00AB};
        pkt_data = 88'hAB_0011_2233_4455_6677_8899;
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        checks++; if (ui_din_valid !== 1'b0) begin errors++; $display("FAIL pkt_latency: valid %b want 0 one edge after strobe", ui_din_valid); end
        tick();
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (ui_din !== exp_w[i] || ui_din_be !== ((i == 6) ? 2'b01 : 2'b11) || ui_din_valid !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL pkt_word%0d: got %h be %b v %b busy %b want %h be %b v 1 busy 1", i, ui_din, ui_din_be, ui_din_valid, busy, exp_w[i], (i == 6) ? 2'b01 : 2'b11);
            end
            tick();
        end
        checks++; if (ui_din_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL pkt_idle: valid %b busy %b want 0 0", ui_din_valid, busy); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_w [7] = '{16'h5AA5, 16'h8899, 16'h6677, 16'h4455, 16'h2233, 16'h0011, 16'h00AB};
        int w = 0;
        int hold = 0;
        pkt_data = 88'hAB_0011_2233_4455_6677_8899;
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        tick();
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (ui_din !== exp_w[w] || ui_din_valid !== 1'b1 || ui_din_be !== ((w == 6) ? 2'b01 : 2'b11)) begin
                errors++;
                $display("FAIL bp_word cycle %0d: got %h be %b v %b want %h v 1", c, ui_din, ui_din_be, ui_din_valid, exp_w[w]);
            end
            if (w == 3 && hold < 5) begin
                ui_din_full = 1'b1;
                hold++;
            end else begin
                ui_din_full = 1'b0;
                w++;
            end
            tick();
        end
        ui_din_full = 1'b0;
        checks++; if (ui_din_valid !== 1'b0) begin errors++; $display("FAIL bp_end: valid %b want 0 after 7 accepted words", ui_din_valid); end
        tick();
    endtask

    task automatic test_overflow();
        logic [87:0] a = 88'h01_0203_0405_0607_0809_0A0B;
        logic [87:0] d = 88'h3C_4D5E_6F70_8192_A3B4_C5D6;
        logic [87:0] junk = 88'hEE_EEEE_EEEE_EEEE_EEEE_EEEE;
        for (int c = 0; c <= 16; c++) begin
            pkt_valid = (c == 0 || c == 2 || c == 4 || c == 8);
            pkt_data = (c == 0) ? a : ((c == 8) ? d : junk);
            tick();
            checks++;
            if (c >= 1 && c <= 7) begin
                if (ui_din_valid !== 1'b1 || ui_din !== pkt_word(a, c - 1)) begin
                    errors++; $display("FAIL ovf_first cycle %0d: got %h v %b want %h v 1", c, ui_din, ui_din_valid, pkt_word(a, c - 1));
                end
            end else if (c >= 9 && c <= 15) begin
                if (ui_din_valid !== 1'b1 || ui_din !== pkt_word(d, c - 9)) begin
                    errors++; $display("FAIL ovf_second cycle %0d: got %h v %b want %h v 1", c, ui_din, ui_din_valid, pkt_word(d, c - 9));
                end
            end else if (ui_din_valid !== 1'b0) begin
                errors++; $display("FAIL ovf_idle cycle %0d: valid %b want 0", c, ui_din_valid);
            end
        end
        pkt_valid = 1'b0;
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL ovf_drop: got %0d want 2", drop_count); end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        pkt_data = 88'h77_6655_4433_2211_00FF_EEDD;
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        repeat (5) tick();
        checks++; if (ui_din !== 16'h4433 || ui_din_valid !== 1'b1) begin errors++; $display("FAIL mid_word4: got %h v %b want 4433 v 1", ui_din, ui_din_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ui_din_valid !== 1'b0 || busy !== 1'b0 || drop_count !== 16'h0000 || ui_din !== 16'h0000) begin
            errors++; $display("FAIL mid_reset: v %b busy %b drop %h din %h want 0 0 0000 0000", ui_din_valid, busy, drop_count, ui_din);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++; if (ui_din_valid !== 1'b0) begin errors++; $display("FAIL mid_resume cycle %0d: valid %b want 0", c, ui_din_valid); end
        end
    endtask

`ifdef FT_TX_STATUS_EN
    task automatic test_arbitration();
        logic [15:0] sw [6] = '{16'hA55A, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'h0001};
        logic [87:0] a = 88'h12_3456_789A_BCDE_F011_2233;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        total_packets = 32'h0000_0010;
        mismatch_packets = 32'h0000_0000;
        for (int c = 0; c <= 15; c++) begin
            pkt_valid = (c == 0 || c == 2);
            stat_req = (c == 0);
            pkt_data = (c == 0) ? a : 88'hFF_FFFF_FFFF_FFFF_FFFF_FFFF;
            tick();
            checks++;
            if (c >= 1 && c <= 7) begin
                if (ui_din_valid !== 1'b1 || ui_din !== pkt_word(a, c - 1)) begin
                    errors++; $display("FAIL arb_pkt cycle %0d: got %h v %b want %h v 1", c, ui_din, ui_din_valid, pkt_word(a, c - 1));
                end
            end else if (c >= 9 && c <= 14) begin
                if (ui_din_valid !== 1'b1 || ui_din !== sw[c-9] || ui_din_be !== 2'b11) begin
                    errors++; $display("FAIL arb_stat cycle %0d: got %h be %b v %b want %h be 11 v 1", c, ui_din, ui_din_be, ui_din_valid, sw[c-9]);
                end
            end else if (ui_din_valid !== 1'b0) begin
                errors++; $display("FAIL arb_idle cycle %0d: valid %b want 0", c, ui_din_valid);
            end
        end
        pkt_valid = 1'b0;
        stat_req = 1'b0;
    endtask
`else
    task automatic test_no_status();
        logic [87:0] a = 88'h11_2233_4455_6677_8899_0123;
        total_packets = 32'hA55A_A55A;
        mismatch_packets = 32'hA55A_A55A;
        for (int c = 0; c < 40; c++) begin
            stat_req = (c % 4 == 0);
            pkt_valid = (c == 1);
            pkt_data = a;
            tick();
            checks++;
            if (c >= 2 && c <= 8) begin
                if (ui_din_valid !== 1'b1 || ui_din !== pkt_word(a, c - 2)) begin
                    errors++; $display("FAIL nostat_pkt cycle %0d: got %h v %b want %h v 1", c, ui_din, ui_din_valid, pkt_word(a, c - 2));
                end
            end else if (ui_din_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL nostat_idle cycle %0d: got %h v %b busy %b want v 0 busy 0", c, ui_din, ui_din_valid, busy);
            end
        end
        stat_req = 1'b0;
        pkt_valid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_packet();
        test_backpressure();
        test_overflow();
        test_reset_mid_frame();
`ifdef FT_TX_STATUS_EN
        test_arbitration();
`else
        test_no_status();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
